// File: rtl/addsub_operand_ctrl_if.sv
// Operand capture / result bus between the board I/O and addsub_operand_ctrl.
// The slave modport is the controller's view; the master modport is the board or bench side.
interface addsub_operand_ctrl_if;
    logic [3:0] sw_val;
    logic       btn_load;
    logic       btn_op;
    logic [3:0] num_1;
    logic [3:0] num_2;
    logic [1:0] state_led;
    logic       op_sub;
    logic       result_valid;

    modport slave (
        input  sw_val,
        input  btn_load,
        input  btn_op,
        output num_1,
        output num_2,
        output state_led,
        output op_sub,
        output result_valid
    );

    modport master (
        output sw_val,
        output btn_load,
        output btn_op,
        input  num_1,
        input  num_2,
        input  state_led,
        input  op_sub,
        input  result_valid
    );
endinterface

// File: rtl/addsub_operand_ctrl.sv
// Debounced two-operand capture and add/sub stage feeding the two-digit display driver.
// Define ADDSUB_DB_BYPASS_EN to drop the debounce counters (buttons act on the synchronised level).
//
// state | meaning
// S_A   | showing live switches, next load captures operand A
// S_B   | showing live switches, next load captures operand B
// S_RES | showing A+B or A-B result
module addsub_operand_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_CNT_W        = 20
) (
    input  logic                  clk_main,
    input  logic                  reset,
    addsub_operand_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_RES = 2'b10
    } state_t;

    logic [3:0] sw_s1, sw_s2;
    logic       ld_s1, ld_s2, op_s1, op_s2;
    logic       ld_stable, op_stable;
    logic       ld_stable_d, op_stable_d;
    logic       load_p, op_p;
    state_t     state;
    logic [3:0] a_reg, b_reg;
    logic [7:0] res_reg;
    logic       op_sub;
    logic       in_res_d;
    logic [3:0] num_1, num_2;
    logic       result_valid;

    always_ff @(posedge clk_main) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            ld_s1 <= 1'b0;
            ld_s2 <= 1'b0;
            op_s1 <= 1'b0;
            op_s2 <= 1'b0;
        end else begin
            sw_s1 <= bus.sw_val;
            sw_s2 <= sw_s1;
            ld_s1 <= bus.btn_load;
            ld_s2 <= ld_s1;
            op_s1 <= bus.btn_op;
            op_s2 <= op_s1;
        end
    end

`ifdef ADDSUB_DB_BYPASS_EN
    assign ld_stable = ld_s2;
    assign op_stable = op_s2;
`else
    logic [DB_CNT_W-1:0] ld_cnt, op_cnt;
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            ld_stable <= 1'b0;
            ld_cnt    <= '0;
            op_stable <= 1'b0;
            op_cnt    <= '0;
        end else begin
            if (ld_s2 == ld_stable) begin
                ld_cnt <= '0;
            end else if (ld_cnt == DB_LAST) begin
                ld_stable <= ld_s2;
                ld_cnt    <= '0;
            end else begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (op_s2 == op_stable) begin
                op_cnt <= '0;
            end else if (op_cnt == DB_LAST) begin
                op_stable <= op_s2;
                op_cnt    <= '0;
            end else begin
                op_cnt <= op_cnt + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk_main) begin
        if (reset) begin
            ld_stable_d <= 1'b0;
            op_stable_d <= 1'b0;
        end else begin
            ld_stable_d <= ld_stable;
            op_stable_d <= op_stable;
        end
    end

    assign load_p = ld_stable & ~ld_stable_d;
    assign op_p   = op_stable & ~op_stable_d;

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state  <= S_A;
            a_reg  <= '0;
            b_reg  <= '0;
            op_sub <= 1'b0;
        end else begin
            if (op_p)
                op_sub <= ~op_sub;
            case (state)
                S_A: if (load_p) begin
                    a_reg <= sw_s2;
                    state <= S_B;
                end
                S_B: if (load_p) begin
                    b_reg <= sw_s2;
                    state <= S_RES;
                end
                S_RES: if (load_p)
                    state <= S_A;
                default: state <= S_A;
            endcase
        end
    end

    always_ff @(posedge clk_main) begin
        if (reset)
            res_reg <= '0;
        else if (!op_sub)
            res_reg <= {4'h0, a_reg} + {4'h0, b_reg};
        else if (a_reg >= b_reg)
            res_reg <= {4'h0, a_reg - b_reg};
        else
            res_reg <= {4'hF, b_reg - a_reg};
    end

    // Valid needs two cycles in S_RES (res_reg refresh), but drops one cycle after leaving.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            num_1        <= '0;
            num_2        <= 4'hA;
            result_valid <= 1'b0;
            in_res_d     <= 1'b0;
        end else begin
            in_res_d     <= (state == S_RES);
            result_valid <= (state == S_RES) && in_res_d;
            case (state)
                S_B: begin
                    num_1 <= sw_s2;
                    num_2 <= 4'hB;
                end
                S_RES: begin
                    num_1 <= res_reg[3:0];
                    num_2 <= res_reg[7:4];
                end
                default: begin
                    num_1 <= sw_s2;
                    num_2 <= 4'hA;
                end
            endcase
        end
    end

    assign bus.num_1        = num_1;
    assign bus.num_2        = num_2;
    assign bus.state_led    = state;
    assign bus.op_sub       = op_sub;
    assign bus.result_valid = result_valid;
endmodule

// File: tb/tb_addsub_operand_ctrl.sv
// Directed bench for addsub_operand_ctrl with DEBOUNCE_CYCLES = 4.
module tb_addsub_operand_ctrl;
    logic clk_main = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    addsub_operand_ctrl_if bus ();

    addsub_operand_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DB_CNT_W        (20)
    ) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_main = ~clk_main;

    task automatic press_load();
        bus.btn_load = 1'b1;
        repeat (10) @(negedge clk_main);
        bus.btn_load = 1'b0;
        repeat (10) @(negedge clk_main);
    endtask

    task automatic press_op();
        bus.btn_op = 1'b1;
        repeat (10) @(negedge clk_main);
        bus.btn_op = 1'b0;
        repeat (10) @(negedge clk_main);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.sw_val   = 4'h0;
        bus.btn_load = 1'b0;
        bus.btn_op   = 1'b0;
        repeat (3) @(negedge clk_main);
        checks++; if (bus.num_1 !== 4'h0) begin errors++; $display("FAIL reset_num_1 got %h want 0", bus.num_1); end
        checks++; if (bus.num_2 !== 4'hA) begin errors++; $display("FAIL reset_num_2 got %h want a", bus.num_2); end
        checks++; if (bus.state_led !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", bus.state_led); end
        checks++; if (bus.op_sub !== 1'b0) begin errors++; $display("FAIL reset_op_sub got %b want 0", bus.op_sub); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.result_valid); end
        reset = 1'b0;
        @(negedge clk_main);
    endtask

    task automatic test_add_carry();
        bus.sw_val = 4'h9;
        press_load();
        checks++; if (bus.state_led !== 2'b01) begin errors++; $display("FAIL add_state_b got %b want 01", bus.state_led); end
        checks++; if (bus.num_2 !== 4'hB) begin errors++; $display("FAIL add_num_2_b got %h want b", bus.num_2); end
        bus.sw_val = 4'h8;
        press_load();
        checks++; if (bus.state_led !== 2'b10) begin errors++; $display("FAIL add_state_res got %b want 10", bus.state_led); end
        checks++; if ({bus.num_2, bus.num_1} !== 8'h11) begin errors++; $display("FAIL add_result got %h want 11", {bus.num_2, bus.num_1}); end
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", bus.result_valid); end
    endtask

    task automatic test_wrap_retain();
        bit found = 1'b0;
        bus.sw_val   = 4'h6;
        repeat (3) @(negedge clk_main);
        bus.btn_load = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_main);
            if (bus.state_led == 2'b00) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wrap_timeout got state %b want 00", bus.state_led); end
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_hold got %b want 1", bus.result_valid); end
        @(negedge clk_main);
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_drop got %b want 0", bus.result_valid); end
        checks++; if ({bus.num_2, bus.num_1} !== 8'hA6) begin errors++; $display("FAIL wrap_display got %h want a6", {bus.num_2, bus.num_1}); end
        bus.btn_load = 1'b0;
        repeat (12) @(negedge clk_main);
    endtask

    task automatic test_sub_negative();
        bit found = 1'b0;
        press_op();
        checks++; if (bus.op_sub !== 1'b1) begin errors++; $display("FAIL sub_op_on got %b want 1", bus.op_sub); end
        bus.sw_val = 4'h3;
        press_load();
        bus.sw_val = 4'h7;
        press_load();
        checks++; if ({bus.num_2, bus.num_1} !== 8'hF4) begin errors++; $display("FAIL sub_negative got %h want f4", {bus.num_2, bus.num_1}); end
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %b want 1", bus.result_valid); end
        bus.btn_op = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_main);
            if (bus.op_sub == 1'b0) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sub_toggle_timeout got %b want 0", bus.op_sub); end
        repeat (2) @(negedge clk_main);
        checks++; if ({bus.num_2, bus.num_1} !== 8'h0A) begin errors++; $display("FAIL sub_recompute got %h want 0a", {bus.num_2, bus.num_1}); end
        bus.btn_op = 1'b0;
        repeat (12) @(negedge clk_main);
        press_load();
        checks++; if (bus.state_led !== 2'b00) begin errors++; $display("FAIL sub_back_to_a got %b want 00", bus.state_led); end
    endtask

    task automatic test_bounce();
        bus.sw_val   = 4'h5;
        bus.btn_load = 1'b1; repeat (2) @(negedge clk_main);
        bus.btn_load = 1'b0; @(negedge clk_main);
        bus.btn_load = 1'b1; repeat (2) @(negedge clk_main);
        bus.btn_load = 1'b0; repeat (12) @(negedge clk_main);
        checks++; if (bus.state_led !== 2'b00) begin errors++; $display("FAIL bounce_rejected got %b want 00", bus.state_led); end
        bus.btn_load = 1'b1; repeat (6) @(negedge clk_main);
        bus.btn_load = 1'b0; repeat (12) @(negedge clk_main);
        checks++; if (bus.state_led !== 2'b01) begin errors++; $display("FAIL bounce_single_advance got %b want 01", bus.state_led); end
    endtask

    task automatic test_reset_mid();
        press_op();
        checks++; if (bus.op_sub !== 1'b1) begin errors++; $display("FAIL mid_op_set got %b want 1", bus.op_sub); end
        reset = 1'b1;
        @(negedge clk_main);
        checks++; if (bus.state_led !== 2'b00) begin errors++; $display("FAIL mid_reset_state got %b want 00", bus.state_led); end
        checks++; if (bus.op_sub !== 1'b0) begin errors++; $display("FAIL mid_reset_op got %b want 0", bus.op_sub); end
        checks++; if (bus.num_2 !== 4'hA) begin errors++; $display("FAIL mid_reset_num_2 got %h want a", bus.num_2); end
        reset = 1'b0;
        bus.sw_val = 4'h0;
        @(negedge clk_main);
        press_load();
        press_load();
        checks++; if (bus.state_led !== 2'b10) begin errors++; $display("FAIL zero_state got %b want 10", bus.state_led); end
        checks++; if ({bus.num_2, bus.num_1} !== 8'h00) begin errors++; $display("FAIL zero_result got %h want 00", {bus.num_2, bus.num_1}); end
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", bus.result_valid); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_wrap_retain();
        test_sub_negative();
        test_bounce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
